fib_stream_gen: RTL and testbench



---
 rtl/fib_stream_gen.sv | 141 ++++++++++++++
 tb/tb_fib_stream_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_gen.sv
// Fibonacci-class term generator with valid/ready output, programmable seeds,
// term limit and wrap-tagging or stop-on-overflow.
module fib_stream_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IDX_W     = 16,
    parameter int unsigned SEED0     = 0,
    parameter int unsigned SEED1     = 1,
    parameter int unsigned MAX_TERMS = 0,
    parameter bit          WRAP      = 1'b1
) (
    input  logic             clock_1,
    input  logic             reset,
    input  logic             start,
    input  logic             f_en,
    input  logic             f_ready,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_out,
    output logic [IDX_W-1:0] f_index,
    output logic             f_ovf,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] S0       = WIDTH'(SEED0);
    localparam logic [WIDTH-1:0] S1       = WIDTH'(SEED1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_TERMS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ca_q, ca_d, cb_q, cb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             f_valid_q, f_valid_d;
    logic [WIDTH-1:0] f_out_q, f_out_d;
    logic [IDX_W-1:0] f_index_q, f_index_d;
    logic             f_ovf_q, f_ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic             xfer;
    logic             slot_free;
    logic             limit_hit;

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        xfer      = f_valid_q && f_ready;
        slot_free = !f_valid_q || xfer;
        limit_hit = (MAX_TERMS != 0) && xfer && (f_index_q == LAST_IDX);

        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        idx_d     = idx_q;
        f_valid_d = f_valid_q;
        f_out_d   = f_out_q;
        f_index_d = f_index_q;
        f_ovf_d   = f_ovf_q;
        done_d    = done_q;

        if (start) begin
            // start overrides any pending term; it is simply dropped
            a_d       = S0;
            b_d       = S1;
            ca_d      = 1'b0;
            cb_d      = 1'b0;
            idx_d     = '0;
            f_valid_d = 1'b0;
            done_d    = 1'b0;
            state_d   = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (limit_hit) begin
                        f_valid_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else if (slot_free && f_en) begin
                        if (!WRAP && ca_q) begin
                            f_valid_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            f_out_d   = a_q;
                            f_index_d = idx_q;
                            f_ovf_d   = ca_q;
                            f_valid_d = 1'b1;
                            a_d       = b_q;
                            b_d       = sum[WIDTH-1:0];
                            ca_d      = cb_q;
                            cb_d      = cb_q | sum[WIDTH];
                            idx_d     = idx_q + IDX_ONE;
                        end
                    end else if (xfer) begin
                        f_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_1) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= S0;
            b_q       <= S1;
            ca_q      <= 1'b0;
            cb_q      <= 1'b0;
            idx_q     <= '0;
            f_valid_q <= 1'b0;
            f_out_q   <= '0;
            f_index_q <= '0;
            f_ovf_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            idx_q     <= idx_d;
            f_valid_q <= f_valid_d;
            f_out_q   <= f_out_d;
            f_index_q <= f_index_d;
            f_ovf_q   <= f_ovf_d;
            done_q    <= done_d;
        end
    end

    assign f_valid = f_valid_q;
    assign f_out   = f_out_q;
    assign f_index = f_index_q;
    assign f_ovf   = f_ovf_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Scoreboard bench for fib_stream_gen: five instances cover default, 8-bit
// wrap, 8-bit stop-on-overflow, term limit and Lucas seeds.
module tb_fib_stream_gen;

    typedef struct {
        logic [15:0] v;
        logic [15:0] i;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        st  [5];
    logic        en  [5];
    logic        rd  [5];
    logic        vld [5];
    logic [15:0] idx [5];
    logic        ovf [5];
    logic        dn  [5];
    logic [15:0] out [5];
    logic [15:0] o0, o3, o4;
    logic [7:0]  o1, o2;

    exp_t q[$];
    int   sel;
    bit   mon_on;
    int   n_pop;
    int   vectors;
    int   miscompares;

    int fib16 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    int fib8  [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    int luc   [6]  = '{2, 1, 3, 4, 7, 11};
    int pat   [4]  = '{1, 0, 0, 1};

    fib_stream_gen u_def (
        .clock_1(clk), .reset(rst), .start(st[0]), .f_en(en[0]), .f_ready(rd[0]),
        .f_valid(vld[0]), .f_out(o0), .f_index(idx[0]), .f_ovf(ovf[0]), .done(dn[0])
    );
    fib_stream_gen #(.WIDTH(8), .WRAP(1'b1)) u_w8wrap (
        .clock_1(clk), .reset(rst), .start(st[1]), .f_en(en[1]), .f_ready(rd[1]),
        .f_valid(vld[1]), .f_out(o1), .f_index(idx[1]), .f_ovf(ovf[1]), .done(dn[1])
    );
    fib_stream_gen #(.WIDTH(8), .WRAP(1'b0)) u_w8stop (
        .clock_1(clk), .reset(rst), .start(st[2]), .f_en(en[2]), .f_ready(rd[2]),
        .f_valid(vld[2]), .f_out(o2), .f_index(idx[2]), .f_ovf(ovf[2]), .done(dn[2])
    );
    fib_stream_gen #(.MAX_TERMS(5)) u_lim (
        .clock_1(clk), .reset(rst), .start(st[3]), .f_en(en[3]), .f_ready(rd[3]),
        .f_valid(vld[3]), .f_out(o3), .f_index(idx[3]), .f_ovf(ovf[3]), .done(dn[3])
    );
    fib_stream_gen #(.SEED0(2), .SEED1(1)) u_luc (
        .clock_1(clk), .reset(rst), .start(st[4]), .f_en(en[4]), .f_ready(rd[4]),
        .f_valid(vld[4]), .f_out(o4), .f_index(idx[4]), .f_ovf(ovf[4]), .done(dn[4])
    );

    always_comb begin
        out[0] = o0;
        out[1] = {8'h00, o1};
        out[2] = {8'h00, o2};
        out[3] = o3;
        out[4] = o4;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // A transfer happens on the next rising edge whenever valid and ready
    // are both high at the falling edge.
    always @(negedge clk) begin
        if (mon_on && vld[sel] && rd[sel]) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_term: dut %0d got %0d at index %0d, expected none", sel, out[sel], idx[sel]);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("term_dut%0d_idx%0d", sel, e.i),
                    {out[sel], idx[sel]}, {e.v, e.i});
                chk($sformatf("ovf_dut%0d_idx%0d", sel, e.i), {31'b0, ovf[sel]}, {31'b0, e.o});
            end
            n_pop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input int i, input logic o);
        exp_t e;
        e.v = 16'(v);
        e.i = 16'(i);
        e.o = o;
        q.push_back(e);
    endtask

    task automatic do_start(input int k);
        mon_on = 1'b0;
        sel    = k;
        st[k]  = 1'b1;
        en[k]  = 1'b0;
        rd[k]  = 1'b1;
        tick();
        st[k]  = 1'b0;
        q.delete();
        n_pop  = 0;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c;
        c = 0;
        while (n_pop < n && c < budget) begin
            tick();
            c++;
        end
        chk($sformatf("pop_count_dut%0d", sel), n_pop, n);
    endtask

    task automatic wait_done(input int k, input int budget);
        int c;
        c = 0;
        while (!dn[k] && c < budget) begin
            tick();
            c++;
        end
        chk($sformatf("done_seen_dut%0d", k), {31'b0, dn[k]}, 1);
    endtask

    initial begin
        int c;
        vectors     = 0;
        miscompares = 0;
        mon_on      = 1'b0;
        sel         = 0;
        n_pop       = 0;
        rst         = 1'b1;
        for (int k = 0; k < 5; k++) begin
            st[k] = 1'b0;
            en[k] = 1'b0;
            rd[k] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++)
            chk($sformatf("reset_dut%0d", k),
                {vld[k], ovf[k], dn[k], out[k], idx[k]}, 0);

        // Default stream with back-pressure on index 5
        do_start(0);
        for (int i = 0; i < 13; i++) push(fib16[i], i, 1'b0);
        mon_on = 1'b1;
        en[0]  = 1'b1;
        c = 0;
        while (!(vld[0] && idx[0] == 16'd5) && c < 20) begin
            tick();
            c++;
        end
        chk("cycles_to_idx5", c, 6);
        rd[0] = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("hold_%0d", h), {vld[0], out[0], idx[0]}, {1'b1, 16'd5, 16'd5});
        end
        rd[0] = 1'b1;
        wait_pops(10, 20);
        mon_on = 1'b0;

        // Enable toggling
        do_start(0);
        for (int i = 0; i < 12; i++) push(fib16[i], i, 1'b0);
        mon_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            en[0] = pat[i % 4][0];
            tick();
            if (pat[i % 4] == 0)
                chk($sformatf("en_low_valid_%0d", i), {31'b0, vld[0]}, 0);
        end
        en[0] = 1'b0;
        wait_pops(8, 5);
        mon_on = 1'b0;

        // 8-bit, wrap with overflow tagging
        do_start(1);
        for (int i = 0; i < 16; i++) push(fib8[i], i, i >= 14);
        mon_on = 1'b1;
        en[1]  = 1'b1;
        wait_pops(16, 40);
        mon_on = 1'b0;
        en[1]  = 1'b0;

        // 8-bit, stop before the first overflowed term
        do_start(2);
        for (int i = 0; i < 14; i++) push(fib8[i], i, 1'b0);
        mon_on = 1'b1;
        en[2]  = 1'b1;
        wait_done(2, 40);
        chk("stop_pops", n_pop, 14);
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("stop_idle_%0d", h), {vld[2], dn[2]}, 2'b01);
        end
        mon_on = 1'b0;

        // Term limit, then restart
        do_start(3);
        for (int i = 0; i < 5; i++) push(fib16[i], i, 1'b0);
        mon_on = 1'b1;
        en[3]  = 1'b1;
        wait_done(3, 20);
        chk("limit_pops", n_pop, 5);
        tick();
        chk("limit_idle", {vld[3], dn[3]}, 2'b01);
        do_start(3);
        chk("restart_done_clr", {31'b0, dn[3]}, 0);
        for (int i = 0; i < 4; i++) push(fib16[i], i, 1'b0);
        mon_on = 1'b1;
        en[3]  = 1'b1;
        wait_pops(4, 10);
        mon_on = 1'b0;

        // Lucas seeds, reset mid-stream, resume
        do_start(4);
        for (int i = 0; i < 6; i++) push(luc[i], i, 1'b0);
        mon_on = 1'b1;
        en[4]  = 1'b1;
        wait_pops(6, 15);
        mon_on = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_outputs", {vld[4], ovf[4], dn[4], out[4], idx[4]}, 0);
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("midreset_idle_%0d", h), {31'b0, vld[4]}, 0);
        end
        do_start(4);
        for (int i = 0; i < 3; i++) push(luc[i], i, 1'b0);
        mon_on = 1'b1;
        en[4]  = 1'b1;
        wait_pops(3, 10);
        mon_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
